// File: rtl/pc_flow_pkg.sv
// Shared opcodes, check indices and monitor FSM states
// for the next-PC flow checker.
package pc_flow_pkg;

  localparam int NUM_CHECKS = 4;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    CHK_JAL      = 2'd0,
    CHK_BR_TAKEN = 2'd1,
    CHK_JALR_EX  = 2'd2,
    CHK_BR_NT    = 2'd3
  } check_e;

  typedef enum logic [1:0] {
    MONITOR = 2'd0,
    ERRSEEN = 2'd1,
    HALT    = 2'd2
  } mon_state_e;

endpackage

// File: rtl/pc_flow_monitor_if.sv
// Observed IF/ID/EX signals feeding the next-PC monitor.
// The pipeline is master; the monitor is a pure slave.
interface pc_flow_monitor_if #(
  parameter int XLEN = 32
);
  logic [31:0]     instruction_id_i;
  logic            branch_condition_i;
  logic            stall_i;
  logic            id_ex_flush_i;
  logic [XLEN-1:0] pc_reg_if_i;
  logic [XLEN-1:0] pc_reg_id_i;
  logic [XLEN-1:0] pc_next_if_i;
  logic [XLEN-1:0] alu_result_ex_i;
  logic [XLEN-1:0] branch_adder_id_i;

  modport master (
    output instruction_id_i, branch_condition_i,
    output stall_i, id_ex_flush_i,
    output pc_reg_if_i, pc_reg_id_i, pc_next_if_i,
    output alu_result_ex_i, branch_adder_id_i
  );

  modport slave (
    input instruction_id_i, branch_condition_i,
    input stall_i, id_ex_flush_i,
    input pc_reg_if_i, pc_reg_id_i, pc_next_if_i,
    input alu_result_ex_i, branch_adder_id_i
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and freeze.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  input  logic         frz,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_cnt <= '0;
    end else if (inc && !frz && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt_o = r_cnt;

endmodule

// File: rtl/pc_flow_monitor.sv
// Runtime checker for next-PC selection: JAL, taken and
// not-taken branches, and JALR redirects from EX.
module pc_flow_monitor
  import pc_flow_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int EX_LAT      = 1,
  parameter int CNT_W       = 16,
  parameter bit HALT_ON_ERR = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable_i,
  input  logic                  clear_i,
  pc_flow_monitor_if.slave      bus,
  output logic [3:0]            err_sticky_o,
  output logic [3:0]            err_pulse_o,
  output logic [4*CNT_W-1:0]    err_cnt_o,
  output logic [CNT_W-1:0]      chk_cnt_o,
  output logic [XLEN-1:0]       first_err_pc_o,
  output logic [1:0]            first_err_id_o,
  output logic                  halted_o
);

  mon_state_e r_state, w_state_nxt;

  logic [6:0]      w_opc;
  logic            w_br_tk;
  logic            w_load;
  logic            w_mature;
  logic            w_eval;
  logic            w_is_jal, w_is_bt, w_is_bn;
  logic [3:0]      w_chk;
  logic [3:0]      w_mis_vec;
  logic            w_mis;
  logic [1:0]      w_chk_id;
  logic [XLEN-1:0] w_exp;
  logic            w_cap;
  logic            w_frz;

  logic [EX_LAT-1:0] r_jalr_v;
  logic [EX_LAT:0]   w_jalr_sh;

  logic [3:0]      r_pulse, r_sticky;
  logic [XLEN-1:0] r_fpc;
  logic [1:0]      r_fid;

  assign w_opc   = bus.instruction_id_i[6:0];
  assign w_br_tk = bus.instruction_id_i[12] ^ bus.branch_condition_i;

  // JALR valid pipe tracks even in HALT and across clear
  assign w_load = (w_opc == OPC_JALR) && enable_i
               && !bus.stall_i && !bus.id_ex_flush_i;
  assign w_jalr_sh = {r_jalr_v, w_load};
  assign w_mature  = r_jalr_v[EX_LAT-1] && !bus.stall_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_jalr_v <= '0;
    end else if (!bus.stall_i) begin
      r_jalr_v <= w_jalr_sh[EX_LAT-1:0];
    end
  end

  assign w_eval   = enable_i && !bus.stall_i && (r_state != HALT);
  assign w_is_jal = !w_mature && (w_opc == OPC_JAL);
  assign w_is_bt  = !w_mature && (w_opc == OPC_BRANCH) && w_br_tk;
  assign w_is_bn  = !w_mature && (w_opc == OPC_BRANCH) && !w_br_tk;

  always_comb begin
    w_chk    = '0;
    w_exp    = '0;
    w_chk_id = '0;
    if (w_eval) begin
      unique case (1'b1)
        w_mature: begin
          w_chk[CHK_JALR_EX] = 1'b1;
          w_exp    = bus.alu_result_ex_i;
          w_chk_id = CHK_JALR_EX;
        end
        w_is_jal: begin
          w_chk[CHK_JAL] = 1'b1;
          w_exp    = bus.branch_adder_id_i;
          w_chk_id = CHK_JAL;
        end
        w_is_bt: begin
          w_chk[CHK_BR_TAKEN] = 1'b1;
          w_exp    = bus.branch_adder_id_i;
          w_chk_id = CHK_BR_TAKEN;
        end
        w_is_bn: begin
          w_chk[CHK_BR_NT] = 1'b1;
          w_exp    = bus.pc_reg_if_i + XLEN'(4);
          w_chk_id = CHK_BR_NT;
        end
        default: ;
      endcase
    end
  end

  assign w_mis_vec = (bus.pc_next_if_i != w_exp) ? w_chk : 4'b0;
  assign w_mis     = |w_mis_vec;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= MONITOR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cap       = 1'b0;
    if (clear_i) begin
      w_state_nxt = MONITOR;
    end else begin
      unique case (r_state)
        MONITOR: begin
          if (w_mis) begin
            w_cap       = 1'b1;
            w_state_nxt = HALT_ON_ERR ? HALT : ERRSEEN;
          end
        end
        ERRSEEN: ;
        HALT:    ;
        default: w_state_nxt = MONITOR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      r_pulse  <= '0;
      r_sticky <= '0;
      r_fpc    <= '0;
      r_fid    <= '0;
    end else begin
      r_pulse  <= w_mis_vec;
      r_sticky <= r_sticky | w_mis_vec;
      if (w_cap) begin
        r_fpc <= bus.pc_reg_id_i;
        r_fid <= w_chk_id;
      end
    end
  end

  assign w_frz = (r_state == HALT);

  for (genvar k = 0; k < NUM_CHECKS; k++) begin : g_err
    sat_counter #(.W(CNT_W)) u_err (
      .clk   (clk),
      .reset (reset),
      .inc   (w_mis_vec[k]),
      .clr   (clear_i),
      .frz   (w_frz),
      .cnt_o (err_cnt_o[k*CNT_W +: CNT_W])
    );
  end

  sat_counter #(.W(CNT_W)) u_chk (
    .clk   (clk),
    .reset (reset),
    .inc   (|w_chk),
    .clr   (clear_i),
    .frz   (w_frz),
    .cnt_o (chk_cnt_o)
  );

  assign err_sticky_o   = r_sticky;
  assign err_pulse_o    = r_pulse;
  assign first_err_pc_o = r_fpc;
  assign first_err_id_o = r_fid;
  assign halted_o       = (r_state == HALT);

endmodule

// File: tb/tb_pc_flow_monitor.sv
// Directed plus random bench for two monitor builds sharing
// one stimulus bus, checked against a queue-based model.
module tb_pc_flow_monitor;

  localparam logic [31:0] I_JAL  = 32'h0000_006F;
  localparam logic [31:0] I_JALR = 32'h0000_0067;
  localparam logic [31:0] I_BEQ  = 32'h0000_0063;
  localparam logic [31:0] I_BNE  = 32'h0000_1063;
  localparam logic [31:0] I_NOP  = 32'h0000_0013;

  logic clk = 1'b0;
  logic reset, enable, clear;

  pc_flow_monitor_if #(.XLEN(32)) bus();

  logic [3:0]  a_sticky, a_pulse, b_sticky, b_pulse;
  logic [7:0]  a_err;
  logic [1:0]  a_chk;
  logic [63:0] b_err;
  logic [15:0] b_chk;
  logic [31:0] a_fpc, b_fpc;
  logic [1:0]  a_fid, b_fid;
  logic        a_halt, b_halt;

  // A: EX_LAT=2, CNT_W=2, no halt.  B: EX_LAT=1, CNT_W=16, halt.
  pc_flow_monitor #(.XLEN(32), .EX_LAT(2), .CNT_W(2),
                    .HALT_ON_ERR(1'b0)) dut_a (
    .clk(clk), .reset(reset), .enable_i(enable),
    .clear_i(clear), .bus(bus.slave),
    .err_sticky_o(a_sticky), .err_pulse_o(a_pulse),
    .err_cnt_o(a_err), .chk_cnt_o(a_chk),
    .first_err_pc_o(a_fpc), .first_err_id_o(a_fid),
    .halted_o(a_halt)
  );

  pc_flow_monitor #(.XLEN(32), .EX_LAT(1), .CNT_W(16),
                    .HALT_ON_ERR(1'b1)) dut_b (
    .clk(clk), .reset(reset), .enable_i(enable),
    .clear_i(clear), .bus(bus.slave),
    .err_sticky_o(b_sticky), .err_pulse_o(b_pulse),
    .err_cnt_o(b_err), .chk_cnt_o(b_chk),
    .first_err_pc_o(b_fpc), .first_err_id_o(b_fid),
    .halted_o(b_halt)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  int     lat [2]  = '{2, 1};
  longint cmax [2] = '{3, 65535};
  bit     hoe [2]  = '{1'b0, 1'b1};

  bit [3:0]    m_sticky [2];
  bit [3:0]    m_pulse  [2];
  longint      m_err    [2][4];
  longint      m_chk    [2];
  logic [31:0] m_fpc    [2];
  bit [1:0]    m_fid    [2];
  bit          m_seen   [2];
  bit          m_halt   [2];

  // unstalled-cycle index at which each JALR entered EX path
  int ldq [$];
  int u = 0;

  task automatic zero_cfg(input int c);
    m_sticky[c] = '0;
    m_pulse[c]  = '0;
    for (int k = 0; k < 4; k++) m_err[c][k] = 0;
    m_chk[c]  = 0;
    m_fpc[c]  = '0;
    m_fid[c]  = '0;
    m_seen[c] = 1'b0;
    m_halt[c] = 1'b0;
  endtask

  task automatic model_edge();
    logic [6:0]  opc;
    logic [31:0] exp;
    bit          mat, mis, tk;
    int          k;
    opc = bus.instruction_id_i[6:0];
    if (reset) begin
      zero_cfg(0);
      zero_cfg(1);
      ldq.delete();
      u = 0;
      return;
    end
    for (int c = 0; c < 2; c++) begin
      mat = 1'b0;
      if (!bus.stall_i)
        foreach (ldq[i]) if (ldq[i] + lat[c] == u) mat = 1'b1;
      k   = -1;
      exp = '0;
      tk  = bus.instruction_id_i[12] ^ bus.branch_condition_i;
      if (enable && !bus.stall_i && !m_halt[c]) begin
        if (mat) begin
          k = 2; exp = bus.alu_result_ex_i;
        end else if (opc == 7'b1101111) begin
          k = 0; exp = bus.branch_adder_id_i;
        end else if (opc == 7'b1100011) begin
          if (tk) begin
            k = 1; exp = bus.branch_adder_id_i;
          end else begin
            k = 3; exp = bus.pc_reg_if_i + 32'd4;
          end
        end
      end
      mis = (k >= 0) && (bus.pc_next_if_i != exp);
      if (clear) begin
        zero_cfg(c);
      end else begin
        m_pulse[c] = mis ? 4'(1 << k) : 4'b0;
        m_sticky[c] |= m_pulse[c];
        if (mis && m_err[c][k] < cmax[c]) m_err[c][k]++;
        if (k >= 0 && m_chk[c] < cmax[c]) m_chk[c]++;
        if (mis && !m_seen[c] && !m_halt[c]) begin
          m_fpc[c]  = bus.pc_reg_id_i;
          m_fid[c]  = 2'(k);
          m_seen[c] = 1'b1;
          m_halt[c] = hoe[c];
        end
      end
    end
    if (!bus.stall_i) begin
      while (ldq.size() > 0 && ldq[0] + 4 <= u) void'(ldq.pop_front());
      if (opc == 7'b1100111 && enable && !bus.id_ex_flush_i)
        ldq.push_back(u);
      u++;
    end
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pack_err(input int c,
                                           input int w);
    logic [63:0] v;
    v = '0;
    for (int k = 0; k < 4; k++)
      v |= 64'(m_err[c][k]) << (k * w);
    return v;
  endfunction

  task automatic check_all();
    chk("A.sticky", 64'(a_sticky), 64'(m_sticky[0]));
    chk("A.pulse",  64'(a_pulse),  64'(m_pulse[0]));
    chk("A.errcnt", 64'(a_err),    pack_err(0, 2));
    chk("A.chkcnt", 64'(a_chk),    64'(m_chk[0]));
    chk("A.fpc",    64'(a_fpc),    64'(m_fpc[0]));
    chk("A.fid",    64'(a_fid),    64'(m_fid[0]));
    chk("A.halted", 64'(a_halt),   64'(m_halt[0]));
    chk("B.sticky", 64'(b_sticky), 64'(m_sticky[1]));
    chk("B.pulse",  64'(b_pulse),  64'(m_pulse[1]));
    chk("B.errcnt", b_err,         pack_err(1, 16));
    chk("B.chkcnt", 64'(b_chk),    64'(m_chk[1]));
    chk("B.fpc",    64'(b_fpc),    64'(m_fpc[1]));
    chk("B.fid",    64'(b_fid),    64'(m_fid[1]));
    chk("B.halted", 64'(b_halt),   64'(m_halt[1]));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic drv(input logic [31:0] ins, input logic cond,
                     input logic stl, input logic fl,
                     input logic [31:0] pif, input logic [31:0] pid,
                     input logic [31:0] nxt, input logic [31:0] alu,
                     input logic [31:0] bad);
    bus.instruction_id_i   = ins;
    bus.branch_condition_i = cond;
    bus.stall_i            = stl;
    bus.id_ex_flush_i      = fl;
    bus.pc_reg_if_i        = pif;
    bus.pc_reg_id_i        = pid;
    bus.pc_next_if_i       = nxt;
    bus.alu_result_ex_i    = alu;
    bus.branch_adder_id_i  = bad;
    cyc();
  endtask

  task automatic nop();
    drv(I_NOP, 0, 0, 0, 32'h10, 32'hC, 32'h14, 32'h0, 32'h0);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    nop();
    clear = 1'b0;
  endtask

  initial begin
    logic [31:0] r, ins, pif, alu, bad;
    reset  = 1'b1;
    enable = 1'b0;
    clear  = 1'b0;
    nop();
    nop();
    reset  = 1'b0;
    enable = 1'b1;
    nop();

    // JAL pass, then JAL mismatch
    drv(I_JAL, 0, 0, 0, 32'h40, 32'h3C, 32'h100, 32'h0, 32'h100);
    drv(I_JAL, 0, 0, 0, 32'h44, 32'h50, 32'h104, 32'h0, 32'h100);
    nop();
    do_clear();

    // JALR then taken branch, redirect must win
    drv(I_JALR, 0, 0, 0, 32'h80, 32'h7C, 32'h84, 32'h2000, 32'h0);
    drv(I_BNE, 0, 0, 0, 32'h84, 32'h80, 32'h2000, 32'h2000, 32'h300);
    drv(I_BNE, 0, 0, 0, 32'h88, 32'h84, 32'h2000, 32'h2000, 32'h300);
    nop();
    // same with the JALR flushed
    drv(I_JALR, 0, 0, 1, 32'h80, 32'h7C, 32'h84, 32'h2000, 32'h0);
    drv(I_BNE, 0, 0, 0, 32'h84, 32'h80, 32'h300, 32'h2000, 32'h300);
    drv(I_BNE, 0, 0, 0, 32'h88, 32'h84, 32'h300, 32'h2000, 32'h300);
    nop();

    // not-taken branch PC+4 wrap, then a wrong target
    drv(I_BEQ, 0, 0, 0, 32'hFFFF_FFFC, 32'hFFFF_FFF8, 32'h0,
        32'h0, 32'h500);
    drv(I_BEQ, 0, 0, 0, 32'hFFFF_FFFC, 32'hFFFF_FFF8, 32'h1_0000,
        32'h0, 32'h500);
    nop();
    do_clear();

    // JALR pending across a 3-cycle stall
    drv(I_JALR, 0, 0, 0, 32'h200, 32'h1FC, 32'h204, 32'h900, 32'h0);
    for (int i = 0; i < 3; i++)
      drv(I_BNE, 0, 1, 0, 32'h204, 32'h200, 32'h123, 32'h900, 32'h0);
    drv(I_NOP, 0, 0, 0, 32'h204, 32'h200, 32'h900, 32'h900, 32'h0);
    drv(I_NOP, 0, 0, 0, 32'h208, 32'h204, 32'h900, 32'h900, 32'h0);
    nop();
    do_clear();

    // saturation, then clear racing a mismatch
    for (int i = 0; i < 5; i++)
      drv(I_JAL, 0, 0, 0, 32'h40, 32'h60 + i, 32'h0, 32'h0, 32'h100);
    clear = 1'b1;
    drv(I_JAL, 0, 0, 0, 32'h40, 32'h70, 32'h0, 32'h0, 32'h100);
    clear = 1'b0;
    nop();

    // halt build: one mismatch then ten more
    for (int i = 0; i < 11; i++)
      drv(I_JAL, 0, 0, 0, 32'h40, 32'hA0 + i, 32'h0, 32'h0, 32'h100);
    do_clear();
    nop();

    for (int n = 0; n < 600; n++) begin
      r = $urandom;
      unique case (r[2:0])
        3'd0, 3'd1: ins = I_JAL;
        3'd2, 3'd3: ins = I_JALR;
        3'd4, 3'd5: ins = (r[3]) ? I_BNE : I_BEQ;
        default:    ins = I_NOP;
      endcase
      ins[31:13] = 19'($urandom);
      pif = (r[7:4] == 4'd0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      alu = $urandom;
      bad = $urandom;
      enable = ($urandom_range(0, 9) != 0);
      clear  = ($urandom_range(0, 39) == 0);
      reset  = ($urandom_range(0, 199) == 0);
      unique case (r[9:8])
        2'd0: bus.pc_next_if_i = bad;
        2'd1: bus.pc_next_if_i = alu;
        2'd2: bus.pc_next_if_i = pif + 32'd4;
        default: bus.pc_next_if_i = $urandom;
      endcase
      drv(ins, r[10], ($urandom_range(0, 4) == 0),
          ($urandom_range(0, 5) == 0), pif, $urandom,
          bus.pc_next_if_i, alu, bad);
    end
    reset  = 1'b0;
    clear  = 1'b0;
    enable = 1'b1;
    nop();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/pc_flow_monitor.md
Name: pc_flow_monitor

Overview:
- Synthesizable runtime checker for next-PC selection in the RV32 pipeline; sits beside the IF/ID stages and observes the same signals as the formal branch checks.
- Generalises those checks in XLEN, JALR resolution latency and counter width; adds a not-taken-branch check, stall awareness, per-check error counters, first-error capture and a halt mode.
- Counters and flags are readable by debug logic or a testbench.

Parameters:
XLEN, 32, width of all PC/address buses
EX_LAT, 1, cycles from JALR in ID to its redirect in EX (1..4)
CNT_W, 16, width of each saturating counter
HALT_ON_ERR, 0, 1 = freeze all counters after the first error until clear_i

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
enable_i  in  1  monitoring enable; 0 = no checks, no enqueue
clear_i  in  1  synchronous clear of flags, counters and capture; returns FSM to MONITOR
instruction_id_i  in  32  instruction in ID
branch_condition_i  in  1  raw comparator result for B-type in ID
stall_i  in  1  IF/ID stall; ID contents not consumed this cycle
id_ex_flush_i  in  1  ID/EX flush; JALR in ID this cycle does not reach EX
pc_reg_if_i  in  XLEN  current IF PC
pc_reg_id_i  in  XLEN  PC of instruction in ID
pc_next_if_i  in  XLEN  selected next PC
alu_result_ex_i  in  XLEN  ALU result in EX (JALR target)
branch_adder_id_i  in  XLEN  ID branch/JAL target
err_sticky_o  out  4  sticky error flag per check
err_pulse_o  out  4  one-cycle pulse per check
err_cnt_o  out  4*CNT_W  per-check error counts, check k at bits [k*CNT_W +: CNT_W]
chk_cnt_o  out  CNT_W  total checks evaluated
first_err_pc_o  out  XLEN  pc_reg_id_i at the first error
first_err_id_o  out  2  check index of the first error
halted_o  out  1  FSM in HALT

Behaviour:
- Check indices:
  - 0 JAL: opcode 1101111.
  - 1 BR_TAKEN: opcode 1100011 and (instr[12] ^ branch_condition_i) = 1.
  - 2 JALR_EX: a pending JALR matures this cycle.
  - 3 BR_NOT_TAKEN: opcode 1100011 and the XOR = 0.
- Expected PC: check 0/1 -> branch_adder_id_i; check 2 -> alu_result_ex_i; check 3 -> pc_reg_if_i + 4, modulo 2^XLEN (wrap at all-ones).
- JALR pipe: EX_LAT-deep valid shift register.
  - Stage 0 loads (opcode 1100111 && enable_i && !stall_i && !id_ex_flush_i).
  - Advances only when !stall_i; holds on stall.
  - A JALR "matures" when the last stage is valid in a cycle with !stall_i.
- Evaluation:
  - Only when enable_i && !stall_i && state != HALT.
  - A maturing JALR: check 2 only; checks 0/1/3 suppressed that cycle (redirect has priority).
  - Otherwise at most one of 0/1/3, decoded from the ID opcode. Non-control opcodes: no check.
- Latency:
  - Mismatch comparison is combinational in cycle N.
  - err_pulse_o[k], err_sticky_o[k], err_cnt and chk_cnt update at N+1.
  - chk_cnt increments on every evaluated check, pass or fail.
- Counters saturate at 2^CNT_W-1; no wrap.
- FSM states:
  - MONITOR -> ERRSEEN on first mismatch; capture first_err_pc_o / first_err_id_o once.
  - ERRSEEN: keep counting; capture is not overwritten.
  - If HALT_ON_ERR=1, the first mismatch goes MONITOR -> HALT instead. HALT: no evaluation, counters frozen, JALR pipe still tracks, halted_o=1.
  - clear_i from any state -> MONITOR. Flags, counters and capture go to 0; the JALR pipe is not cleared.
- clear_i and a mismatch in the same cycle: clear wins; the mismatch is dropped.
- Reset: all outputs 0, JALR pipe empty, state MONITOR. Reset mid-flight discards pending JALRs.
- enable_i=0: pipe does not enqueue but keeps shifting; JALRs already enqueued still mature and are checked only if enable_i=1 at maturity.

Decomposition:
- Package pc_flow_pkg:
  - opcode constants OPC_JAL, OPC_JALR, OPC_BRANCH
  - check index enum check_e
  - FSM typedef mon_state_e {MONITOR, ERRSEEN, HALT}
  - NUM_CHECKS=4
- Sub-module sat_counter (parameter W; inc, clr, frz): instantiated 5 times, 4 error counters plus chk_cnt.

Test Plan:
- JAL in ID, branch_adder_id_i=0x100, pc_next_if_i=0x100 -> no pulse, chk_cnt=1; repeat with pc_next_if_i=0x104 -> err_pulse_o=0001 next cycle, first_err_pc_o=pc_reg_id_i, first_err_id_o=0.
- JALR in ID (EX_LAT=2, no flush) followed by B-type taken, alu_result_ex_i=0x2000, pc_next_if_i=0x2000 at maturity -> check 2 passes and check 1 is suppressed; same stimulus with id_ex_flush_i=1 on the JALR cycle -> no check 2, check 1 is evaluated.
- B-type not taken, pc_reg_if_i=0xFFFF_FFFC, pc_next_if_i=0x0000_0000 -> pass (wrap); pc_next_if_i=0x1_0000 -> err_pulse_o=1000.
- stall_i=1 for 3 cycles with JALR pending (EX_LAT=1) -> no check during the stall; check 2 fires on the first unstalled cycle.
- CNT_W=2, 5 consecutive JAL mismatches -> err_cnt[0] saturates at 3; clear_i together with a 6th mismatch -> all counters 0, sticky 0.
- HALT_ON_ERR=1, one mismatch then 10 more -> halted_o=1, err_cnt[0]=1; clear_i -> halted_o=0, state MONITOR.
